// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM among requesters.
// Supports locked bursts and returns read valids aligned to RAM latency.
module sram_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int WE_W       = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_a,
    input  logic [NUM_REQ*WE_W-1:0]   req_we,
    input  logic [NUM_REQ*DATA_W-1:0] req_di,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      RAM_EN,
    output logic [ADDR_W-1:0]         RAM_A,
    output logic [WE_W-1:0]           RAM_WE,
    output logic [DATA_W-1:0]         RAM_Di,
    input  logic [DATA_W-1:0]         RAM_Do,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {ARB, OWNED} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] gidx;
    logic             found;
    logic             rd_push;

    logic [RD_LATENCY-1:0] pipe_vld;
    logic [IDX_W-1:0]      pipe_id [RD_LATENCY];

    function automatic logic [IDX_W-1:0] rot_idx(
        input logic [IDX_W-1:0] base,
        input int               off
    );
        int j;
        j = int'(base) + off;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        return IDX_W'(j);
    endfunction

    // State, scan pointer and burst owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
        end
    end

    // Pick the granted requester and compute next arbitration state
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        found   = 1'b0;
        gidx    = '0;
        if (rst_n) begin
            unique case (state)
                ARB: begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (!found && req[rot_idx(ptr, i)]) begin
                            found = 1'b1;
                            gidx  = rot_idx(ptr, i);
                        end
                    end
                    if (found) begin
                        if (lock[gidx]) begin
                            state_n = OWNED;
                            owner_n = gidx;
                        end else begin
                            ptr_n = rot_idx(gidx, 1);
                        end
                    end
                end
                OWNED: begin
                    gidx  = owner;
                    found = req[owner];
                    if (!(req[owner] && lock[owner])) begin
                        state_n = ARB;
                        ptr_n   = rot_idx(owner, 1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Grant vector and RAM port mux for the granted slice
    always_comb begin
        gnt    = '0;
        RAM_EN = 1'b0;
        RAM_A  = '0;
        RAM_WE = '0;
        RAM_Di = '0;
        if (found) begin
            gnt[gidx] = 1'b1;
            RAM_EN    = 1'b1;
            RAM_A     = req_a[int'(gidx)*ADDR_W +: ADDR_W];
            RAM_WE    = req_we[int'(gidx)*WE_W +: WE_W];
            RAM_Di    = req_di[int'(gidx)*DATA_W +: DATA_W];
        end
        rd_push = found && (RAM_WE == '0);
    end

    // Read tag pipeline matching RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_id[i] <= '0;
        end else begin
            pipe_vld[0] <= rd_push;
            pipe_id[0]  <= gidx;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    // Decode pipeline tail into per-requester valid and busy flag
    always_comb begin
        rvalid = '0;
        if (pipe_vld[RD_LATENCY-1]) rvalid[pipe_id[RD_LATENCY-1]] = 1'b1;
        busy = (|gnt) | (state == OWNED) | (|pipe_vld);
    end

    assign rdata = RAM_Do;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vectors, RAM model,
// and a queue-based read scoreboard checked by a separate monitor.
module tb_sram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, lock, gnt, rvalid;
    logic [N*AW-1:0] req_a;
    logic [N*WW-1:0] req_we;
    logic [N*DW-1:0] req_di;
    logic [DW-1:0]   rdata, RAM_Di, RAM_Do;
    logic            RAM_EN, busy;
    logic [AW-1:0]   RAM_A;
    logic [WW-1:0]   RAM_WE;

    typedef struct {
        int          k;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] mem [512];
    int          cyc_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .req_a(req_a), .req_we(req_we), .req_di(req_di),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .RAM_EN(RAM_EN), .RAM_A(RAM_A), .RAM_WE(RAM_WE),
        .RAM_Di(RAM_Di), .RAM_Do(RAM_Do), .busy(busy)
    );

    // Single-port RAM model, one-cycle read latency
    always @(posedge clk) begin
        if (RAM_EN) begin
            if (RAM_WE != '0) begin
                for (int b = 0; b < WW; b++)
                    if (RAM_WE[b]) mem[RAM_A][8*b +: 8] <= RAM_Di[8*b +: 8];
            end else begin
                RAM_Do <= mem[RAM_A];
            end
        end
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d);
        exp_t x;
        x.k = k;
        x.d = d;
        x.c = cyc_cnt + 1;
        q.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rvalid must match the oldest expected read
    always @(negedge clk) begin
        if (rvalid != '0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rvalid: got %b expected none", rvalid);
            end else begin
                e = q.pop_front();
                chk("rvalid", {61'd0, rvalid}, 64'(3'b001 << e.k));
                chk("rdata", {32'd0, rdata}, {32'd0, e.d});
                chk("rvalid_cycle", 64'(cyc_cnt), 64'(e.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[5] = 32'hDEAD_BEEF;
        rst_n  = 1'b0;
        req    = 3'b111;
        lock   = 3'b111;
        req_a  = '0;
        req_we = '0;
        req_di = '0;
        req_a[0*AW +: AW] = 9'd7;
        req_we[1*WW +: WW] = 4'h3;
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ram_en", RAM_EN, 0);
        chk("rst_ram_a", RAM_A, 0);
        chk("rst_rvalid", rvalid, 0);
        tick;
        tick;
        req    = '0;
        lock   = '0;
        req_we = '0;
        rst_n  = 1'b1;

        // T1 single read
        tick;
        req = 3'b001;
        req_a[0*AW +: AW] = 9'd5;
        #2;
        chk("t1_gnt", gnt, 3'b001);
        chk("t1_ram_en", RAM_EN, 1);
        chk("t1_ram_a", RAM_A, 5);
        chk("t1_ram_we", RAM_WE, 0);
        push(0, 32'hDEAD_BEEF);

        // requester 2 read brings ptr back to 0
        tick;
        req = 3'b100;
        req_a[2*AW +: AW] = 9'd20;
        #2;
        chk("pre_gnt", gnt, 3'b100);
        push(2, 32'hC0DE_0014);

        // T2 round robin
        for (int i = 0; i < 6; i++) begin
            tick;
            if (i == 0) begin
                req = 3'b111;
                req_a[0*AW +: AW] = 9'd30;
                req_a[1*AW +: AW] = 9'd31;
                req_a[2*AW +: AW] = 9'd32;
            end
            #2;
            chk("t2_gnt", gnt, 3'b001 << (i % 3));
            push(i % 3, 32'hC0DE_001E + (i % 3));
        end

        // T3 locked burst with requester 1 waiting
        tick;
        req  = 3'b011;
        lock = 3'b001;
        req_a[0*AW +: AW] = 9'd11;
        req_a[1*AW +: AW] = 9'd40;
        #2;
        chk("t3_gnt_a", gnt, 3'b001);
        push(0, 32'hC0DE_000B);
        tick;
        req_a[0*AW +: AW] = 9'd12;
        #2;
        chk("t3_gnt_b", gnt, 3'b001);
        chk("t3_busy", busy, 1);
        push(0, 32'hC0DE_000C);
        tick;
        req_a[0*AW +: AW] = 9'd13;
        lock = 3'b000;
        #2;
        chk("t3_gnt_c", gnt, 3'b001);
        push(0, 32'hC0DE_000D);
        tick;
        req = 3'b010;
        #2;
        chk("t3_gnt_d", gnt, 3'b010);
        push(1, 32'hC0DE_0028);

        // T4 write then read
        tick;
        req = 3'b100;
        req_a[2*AW +: AW]  = 9'd9;
        req_we[2*WW +: WW] = 4'hF;
        req_di[2*DW +: DW] = 32'h0000_00AA;
        #2;
        chk("t4_gnt_w", gnt, 3'b100);
        chk("t4_ram_we", RAM_WE, 4'hF);
        chk("t4_ram_di", RAM_Di, 32'h0000_00AA);
        chk("t4_ram_a", RAM_A, 9);
        tick;
        req_we[2*WW +: WW] = 4'h0;
        #2;
        chk("t4_gnt_r", gnt, 3'b100);
        chk("t4_ram_we_r", RAM_WE, 0);
        push(2, 32'h0000_00AA);

        // T5 owner drops request while locked
        tick;
        req  = 3'b001;
        lock = 3'b001;
        req_a[0*AW +: AW] = 9'd50;
        #2;
        chk("t5_gnt_a", gnt, 3'b001);
        push(0, 32'hC0DE_0032);
        tick;
        req  = 3'b010;
        lock = 3'b000;
        req_a[1*AW +: AW] = 9'd51;
        #2;
        chk("t5_gnt_idle", gnt, 3'b000);
        chk("t5_ram_en", RAM_EN, 0);
        chk("t5_busy", busy, 1);
        tick;
        #2;
        chk("t5_gnt_b", gnt, 3'b010);
        push(1, 32'hC0DE_0033);
        tick;
        req = 3'b000;
        #2;
        chk("idle_gnt", gnt, 0);

        // T6 reset mid-burst with a read in flight
        tick;
        req  = 3'b001;
        lock = 3'b001;
        req_a[0*AW +: AW] = 9'd60;
        #2;
        chk("t6_gnt", gnt, 3'b001);
        tick;
        rst_n = 1'b0;
        #2;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_rvalid", rvalid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ram_en", RAM_EN, 0);
        tick;
        tick;
        rst_n = 1'b1;
        req   = 3'b110;
        lock  = 3'b000;
        req_a[1*AW +: AW] = 9'd70;
        #2;
        chk("t6_gnt_after", gnt, 3'b010);
        push(1, 32'hC0DE_0046);
        tick;
        req = 3'b000;
        repeat (4) tick;
        #2;
        chk("end_busy", busy, 0);
        chk("sb_drained", 64'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
